// File: rtl/id_decode_scoreboard_if.sv
// Decode-stage bus: IF/ID fields and write-back port in, read data/immediates/stall out.
// master drives the instruction and write-back side; slave is the decode stage.
interface id_decode_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
);
  logic              stall_flag_id_in;
  logic [ADDR_W-1:0] inst_read_reg_addr1;
  logic [ADDR_W-1:0] inst_read_reg_addr2;
  logic [ADDR_W-1:0] rd;
  logic [IMM_W-1:0]  inst_imm_field;
  logic              reg_dst;
  logic              reg_write_cu;
  logic              reg_write;
  logic [ADDR_W-1:0] reg_wr_addr_wb;
  logic [DATA_W-1:0] reg_wr_data;
  logic [DATA_W-1:0] reg_file_rd_data1;
  logic [DATA_W-1:0] reg_file_rd_data2;
  logic [DATA_W-1:0] sgn_ext_imm;
  logic [DATA_W-1:0] imm_sgn_ext_lft_shft;
  logic [IMM_W-1:0]  imm_field_wo_sgn_ext;
  logic [ADDR_W-1:0] rd_out_id;
  logic              stall_flag_id_out;

  modport master (
    output stall_flag_id_in, inst_read_reg_addr1, inst_read_reg_addr2, rd,
           inst_imm_field, reg_dst, reg_write_cu, reg_write, reg_wr_addr_wb, reg_wr_data,
    input  reg_file_rd_data1, reg_file_rd_data2, sgn_ext_imm, imm_sgn_ext_lft_shft,
           imm_field_wo_sgn_ext, rd_out_id, stall_flag_id_out
  );

  modport slave (
    input  stall_flag_id_in, inst_read_reg_addr1, inst_read_reg_addr2, rd,
           inst_imm_field, reg_dst, reg_write_cu, reg_write, reg_wr_addr_wb, reg_wr_data,
    output reg_file_rd_data1, reg_file_rd_data2, sgn_ext_imm, imm_sgn_ext_lft_shft,
           imm_field_wo_sgn_ext, rd_out_id, stall_flag_id_out
  );
endinterface

// File: rtl/id_decode_scoreboard.sv
// Decode stage: regfile (0-cycle reads), sign extend, dest mux, busy scoreboard raising RAW stall; rd_out_id/imm 1 cycle.
// Stall holds the output registers and blocks scoreboard sets. `define ID_WB_BYPASS_EN for write-back write-through/early release.
module id_decode_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int IMM_W    = 16
) (
  input logic                  clk,
  input logic                  reset,
  id_decode_scoreboard_if.slave bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] busy_eff;
  logic [ADDR_W-1:0]   rd_out_q, rd_out_d;
  logic [IMM_W-1:0]    imm_q, imm_d;

  logic [ADDR_W-1:0]   rs, rt, dest, wb_addr;
  logic                wr_en;
  logic                hazard;
  logic                stall;
  logic                set_en;

  assign rs      = bus.inst_read_reg_addr1;
  assign rt      = bus.inst_read_reg_addr2;
  assign wb_addr = bus.reg_wr_addr_wb;
  assign dest    = bus.reg_dst ? bus.rd : rt;
  assign wr_en   = bus.reg_write && (wb_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wb_addr] <= bus.reg_wr_data;
    end
  end

  always_comb begin
    bus.reg_file_rd_data1 = (rs == '0) ? '0 : regs_q[rs];
    bus.reg_file_rd_data2 = (rt == '0) ? '0 : regs_q[rt];
`ifdef ID_WB_BYPASS_EN
    if (wr_en && (wb_addr == rs)) bus.reg_file_rd_data1 = bus.reg_wr_data;
    if (wr_en && (wb_addr == rt)) bus.reg_file_rd_data2 = bus.reg_wr_data;
`endif
  end

  assign bus.sgn_ext_imm          = {{(DATA_W-IMM_W){bus.inst_imm_field[IMM_W-1]}}, bus.inst_imm_field};
  assign bus.imm_sgn_ext_lft_shft = {bus.sgn_ext_imm[DATA_W-3:0], 2'b00};

  // A retiring write-back masks its busy bit only when write-through is available.
  always_comb begin
    busy_eff = busy_q;
`ifdef ID_WB_BYPASS_EN
    if (bus.reg_write) busy_eff[wb_addr] = 1'b0;
`endif
  end

  assign hazard = ((rs != '0) && busy_eff[rs]) || ((rt != '0) && busy_eff[rt]);
  assign stall  = bus.stall_flag_id_in || hazard;
  assign set_en = bus.reg_write_cu && !stall && (dest != '0);
  assign bus.stall_flag_id_out = stall;

  // Clear before set so a new producer issuing this cycle keeps its bit.
  always_comb begin
    busy_d = busy_q;
    if (bus.reg_write) busy_d[wb_addr] = 1'b0;
    if (set_en)        busy_d[dest]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rd_out_d = rd_out_q;
    imm_d    = imm_q;
    if (!stall) begin
      rd_out_d = dest;
      imm_d    = bus.inst_imm_field;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= '0;
      rd_out_q <= '0;
      imm_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      rd_out_q <= rd_out_d;
      imm_q    <= imm_d;
    end
  end

  assign bus.rd_out_id            = rd_out_q;
  assign bus.imm_field_wo_sgn_ext = imm_q;

endmodule

// File: tb/tb_id_decode_scoreboard.sv
module tb_id_decode_scoreboard;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  id_decode_scoreboard_if ifc ();

  id_decode_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ifc.stall_flag_id_in    = 1'b0;
    ifc.inst_read_reg_addr1 = 5'd0;
    ifc.inst_read_reg_addr2 = 5'd0;
    ifc.rd                  = 5'd0;
    ifc.inst_imm_field      = 16'h0;
    ifc.reg_dst             = 1'b0;
    ifc.reg_write_cu        = 1'b0;
    ifc.reg_write           = 1'b0;
    ifc.reg_wr_addr_wb      = 5'd0;
    ifc.reg_wr_data         = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    ifc.inst_read_reg_addr1 = 5'd5;
    ifc.inst_read_reg_addr2 = 5'd7;
    #1;
    chk("rst_rd1", ifc.reg_file_rd_data1, 32'h0);
    chk("rst_rd2", ifc.reg_file_rd_data2, 32'h0);
    chk("rst_stall", {31'd0, ifc.stall_flag_id_out}, 32'd0);
    chk("rst_rd_out", {27'd0, ifc.rd_out_id}, 32'd0);
    chk("rst_imm_out", {16'd0, ifc.imm_field_wo_sgn_ext}, 32'd0);

    // write-back r3, read next cycle
    ifc.reg_write      = 1'b1;
    ifc.reg_wr_addr_wb = 5'd3;
    ifc.reg_wr_data    = 32'h0000_00AA;
    tick();
    ifc.reg_write           = 1'b0;
    ifc.inst_read_reg_addr1 = 5'd3;
    #1;
    chk("r3_read", ifc.reg_file_rd_data1, 32'h0000_00AA);

    // write to r0 is ignored
    ifc.reg_write           = 1'b1;
    ifc.reg_wr_addr_wb      = 5'd0;
    ifc.reg_wr_data         = 32'hFFFF_FFFF;
    ifc.inst_read_reg_addr1 = 5'd0;
    #1;
    chk("r0_during_wb", ifc.reg_file_rd_data1, 32'h0);
    tick();
    ifc.reg_write = 1'b0;
    #1;
    chk("r0_after_wb", ifc.reg_file_rd_data1, 32'h0);

    // sign extension
    ifc.inst_imm_field = 16'h8004;
    #1;
    chk("sext_neg", ifc.sgn_ext_imm, 32'hFFFF_8004);
    chk("shl_neg", ifc.imm_sgn_ext_lft_shft, 32'hFFFE_0010);
    ifc.inst_imm_field = 16'h7FFF;
    #1;
    chk("sext_pos", ifc.sgn_ext_imm, 32'h0000_7FFF);
    chk("shl_pos", ifc.imm_sgn_ext_lft_shft, 32'h0001_FFFC);

    // issue producer of r9 (R-type)
    ifc.reg_dst             = 1'b1;
    ifc.rd                  = 5'd9;
    ifc.inst_read_reg_addr1 = 5'd0;
    ifc.inst_read_reg_addr2 = 5'd4;
    ifc.reg_write_cu        = 1'b1;
    ifc.inst_imm_field      = 16'h1234;
    #1;
    chk("issue_no_stall", {31'd0, ifc.stall_flag_id_out}, 32'd0);
    tick();
    chk("rd_out_9", {27'd0, ifc.rd_out_id}, 32'd9);
    chk("imm_out_1234", {16'd0, ifc.imm_field_wo_sgn_ext}, 32'h1234);

    // dependent instruction on r9 stalls and holds outputs
    ifc.reg_dst             = 1'b0;
    ifc.inst_read_reg_addr1 = 5'd9;
    ifc.inst_read_reg_addr2 = 5'd0;
    ifc.inst_imm_field      = 16'h5555;
    #1;
    chk("raw_stall", {31'd0, ifc.stall_flag_id_out}, 32'd1);
    tick();
    chk("hold_rd_out", {27'd0, ifc.rd_out_id}, 32'd9);
    chk("hold_imm_out", {16'd0, ifc.imm_field_wo_sgn_ext}, 32'h1234);
    chk("raw_stall_2", {31'd0, ifc.stall_flag_id_out}, 32'd1);

    // write-back of r9 releases the stall
    ifc.reg_write      = 1'b1;
    ifc.reg_wr_addr_wb = 5'd9;
    ifc.reg_wr_data    = 32'hDEAD_BEEF;
    #1;
`ifdef ID_WB_BYPASS_EN
    chk("wb_same_stall", {31'd0, ifc.stall_flag_id_out}, 32'd0);
    chk("wb_same_data", ifc.reg_file_rd_data1, 32'hDEAD_BEEF);
    tick();
    ifc.reg_write = 1'b0;
    #1;
    chk("wb_next_stall", {31'd0, ifc.stall_flag_id_out}, 32'd0);
    chk("wb_next_data", ifc.reg_file_rd_data1, 32'hDEAD_BEEF);
    chk("wb_next_rd_out", {27'd0, ifc.rd_out_id}, 32'd0);
    chk("wb_next_imm", {16'd0, ifc.imm_field_wo_sgn_ext}, 32'h5555);
`else
    chk("wb_same_stall", {31'd0, ifc.stall_flag_id_out}, 32'd1);
    chk("wb_same_data", ifc.reg_file_rd_data1, 32'h0);
    tick();
    ifc.reg_write = 1'b0;
    #1;
    chk("wb_next_stall", {31'd0, ifc.stall_flag_id_out}, 32'd0);
    chk("wb_next_data", ifc.reg_file_rd_data1, 32'hDEAD_BEEF);
    chk("wb_next_rd_out", {27'd0, ifc.rd_out_id}, 32'd9);
    chk("wb_next_imm", {16'd0, ifc.imm_field_wo_sgn_ext}, 32'h1234);
`endif

    // make r6 busy, then clear and re-set it in the same cycle
    ifc.inst_read_reg_addr1 = 5'd0;
    ifc.inst_read_reg_addr2 = 5'd0;
    ifc.reg_dst             = 1'b1;
    ifc.rd                  = 5'd6;
    ifc.reg_write_cu        = 1'b1;
    tick();
    ifc.reg_write      = 1'b1;
    ifc.reg_wr_addr_wb = 5'd6;
    ifc.reg_wr_data    = 32'h0000_0066;
    tick();
    ifc.reg_write           = 1'b0;
    ifc.reg_write_cu        = 1'b0;
    ifc.inst_read_reg_addr1 = 5'd6;
    #1;
    chk("set_wins", {31'd0, ifc.stall_flag_id_out}, 32'd1);

    // external stall with no hazard: no busy bit set, outputs hold
    ifc.inst_read_reg_addr1 = 5'd0;
    ifc.stall_flag_id_in    = 1'b1;
    ifc.reg_write_cu        = 1'b1;
    ifc.rd                  = 5'd12;
    #1;
    chk("ext_stall", {31'd0, ifc.stall_flag_id_out}, 32'd1);
    tick();
    ifc.stall_flag_id_in    = 1'b0;
    ifc.reg_write_cu        = 1'b0;
    ifc.inst_read_reg_addr1 = 5'd12;
    #1;
    chk("ext_no_set", {31'd0, ifc.stall_flag_id_out}, 32'd0);
    chk("ext_hold_rd", {27'd0, ifc.rd_out_id}, 32'd6);

    // reset mid-run overrides a concurrent write and clears busy bits
    reset                   = 1'b1;
    ifc.reg_write           = 1'b1;
    ifc.reg_wr_addr_wb      = 5'd5;
    ifc.reg_wr_data         = 32'h1111_2222;
    tick();
    reset                   = 1'b0;
    ifc.reg_write           = 1'b0;
    ifc.inst_read_reg_addr1 = 5'd3;
    ifc.inst_read_reg_addr2 = 5'd5;
    #1;
    chk("rst2_r3", ifc.reg_file_rd_data1, 32'h0);
    chk("rst2_r5", ifc.reg_file_rd_data2, 32'h0);
    chk("rst2_rd_out", {27'd0, ifc.rd_out_id}, 32'd0);
    ifc.inst_read_reg_addr1 = 5'd6;
    #1;
    chk("rst2_busy6", {31'd0, ifc.stall_flag_id_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_decode_scoreboard.md
Name: id_decode_scoreboard

Overview:
- Instruction-decode stage of the 5-stage pipeline.
- Contains the 32x32 register file, the 16-to-32 sign extender, and the destination-register select mux (rt vs rd).
- Also contains a per-register busy scoreboard, which raises a decode stall on read-after-write hazards until the producing write-back retires.
- Sits between the IF/ID pipeline register and the ID/EX pipeline register; write-back drives its write port.

Parameters:
- DATA_W, 32, register and immediate-extension data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, register count (2**ADDR_W)
- IMM_W, 16, instruction immediate field width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_flag_id_in  in  1  upstream/global stall request
- inst_read_reg_addr1  in  5  rs source address
- inst_read_reg_addr2  in  5  rt source address; also the I-type destination
- rd  in  5  R-type destination address
- inst_imm_field  in  16  instruction immediate
- reg_dst  in  1  1 = destination is rd, 0 = destination is rt
- reg_write_cu  in  1  decoded instruction will write a register
- reg_write  in  1  write-back write enable
- reg_wr_addr_wb  in  5  write-back address
- reg_wr_data  in  32  write-back data
- reg_file_rd_data1  out  32  rs read data
- reg_file_rd_data2  out  32  rt read data
- sgn_ext_imm  out  32  sign-extended immediate
- imm_sgn_ext_lft_shft  out  32  sgn_ext_imm << 2
- imm_field_wo_sgn_ext  out  16  registered raw immediate
- rd_out_id  out  5  registered selected destination
- stall_flag_id_out  out  1  decode stall

Behaviour:
- Reset (sync, clk edge with reset=1):
  - all registers and all 32 busy bits clear to 0
  - rd_out_id = 0, imm_field_wo_sgn_ext = 0
  - reset overrides any write or scoreboard update in the same cycle
- Destination mux: dest = reg_dst ? rd : inst_read_reg_addr2; combinational.
- Register file:
  - 2 combinational read ports, 1 synchronous write port.
  - Write occurs when reg_write=1 and reg_wr_addr_wb != 0.
  - Register 0 always reads 0; writes to it are ignored.
- Sign extend:
  - sgn_ext_imm = {16{imm[15]}, imm}; combinational.
  - imm_sgn_ext_lft_shft = sgn_ext_imm << 2; upper bits are discarded, low 2 bits are 0.
- Scoreboard:
  - busy[i] = 1 means an issued instruction will write register i and has not yet written back.
  - Clear: reg_write=1 clears busy[reg_wr_addr_wb] on the clock edge.
  - Set: reg_write_cu=1 and stall_flag_id_out=0 and dest != 0 sets busy[dest] on the clock edge.
  - Set and clear of the same register in one cycle: set wins (a new producer has issued).
  - busy[0] is never set.
- Hazard:
  - hazard = (rs != 0 and busy_eff[rs]) or (rt != 0 and busy_eff[rt]).
  - rt is checked unconditionally (conservative).
- stall_flag_id_out = stall_flag_id_in or hazard; combinational, no latency.
- Output registers, on each rising edge when not in reset:
  - if stall_flag_id_out=0: rd_out_id <= dest and imm_field_wo_sgn_ext <= inst_imm_field
  - else both hold their value
- Latency:
  - read data, extension and stall: 0 cycles
  - rd_out_id and imm_field_wo_sgn_ext: 1 cycle
  - busy set is visible on the next cycle

Optional Feature:
- Macro: ID_WB_BYPASS_EN
- Defined:
  - Write-through: a read port whose address equals reg_wr_addr_wb while reg_write=1 (address != 0) returns reg_wr_data in the same cycle.
  - busy_eff[i] = busy[i] and not (reg_write and reg_wr_addr_wb == i). A retiring write-back therefore releases the stall in the same cycle.
- Undefined:
  - Reads return the stored value.
  - busy_eff = busy.
  - The stall releases one cycle after the write-back edge.

Test Plan:
- Reset, then read r5/r7 -> both 0; stall_flag_id_out=0, rd_out_id=0, imm_field_wo_sgn_ext=0.
- Write-back r3=0x0000_00AA (reg_write=1), next cycle read rs=3 -> 0xAA. Write-back to r0=0xFFFF_FFFF -> r0 reads 0.
- inst_imm_field=0x8004 -> sgn_ext_imm=0xFFFF_8004, imm_sgn_ext_lft_shft=0xFFFE_0010. 0x7FFF -> 0x0000_7FFF / 0x0001_FFFC.
- reg_dst=1, rd=9, rt=4, reg_write_cu=1 -> rd_out_id=9 next cycle and busy[9] set. Following instruction with rs=9 -> stall_flag_id_out=1; rd_out_id and imm_field_wo_sgn_ext hold.
- While stalled on r9, apply write-back reg_wr_addr_wb=9, reg_write=1:
  - without ID_WB_BYPASS_EN: stall drops the next cycle
  - with ID_WB_BYPASS_EN: stall drops in the same cycle and rd_data1 = reg_wr_data
- Same cycle: write-back clears r6 and a new issue sets r6 -> busy[6]=1 afterwards. stall_flag_id_in=1 with no hazard -> stall_flag_id_out=1 and no busy bit set.
